// File: rtl/div_sched.sv
// div_sched - run/stop controller and reconfiguration scheduler for the
// clock-divider path.
//
// Divides clk into clk_out (period 2*half_cur, 50% duty) with a one-cycle tick
// on every clk_out rise. A new half-period arrives over a valid/ready handshake.
// It is held in a one-entry pending slot and applied only when clk_out falls at
// the end of a full period, so clk_out never glitches. Start and stop are clean:
// clk_out idles low, and a period that has started is always completed.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   en         in   run request (0 = stop at the next falling boundary)
//   cfg_valid  in   new half-period offered on cfg_half
//   cfg_half   in   requested half-period in clk cycles (0 is stored as 1)
//   cfg_ready  out  pending slot empty; transfer when cfg_valid & cfg_ready
//   clk_out    out  divided clock
//   tick       out  one-cycle pulse coincident with clk_out rising
//   busy       out  1 in RUN or STOPPING
//   half_cur   out  half-period currently in effect
//   period_cnt out  (DIV_SCHED_PCNT_EN only) saturating count of clk_out falls
//
// Optional feature: define DIV_SCHED_PCNT_EN to add the period_cnt output.
//
// State    | Meaning
// IDLE     | stopped, clk_out low, an accepted config goes straight to half_cur
// RUN      | dividing; configs wait in the pending slot until clk_out falls
// STOPPING | en dropped; keep dividing until clk_out falls, then IDLE

module div_sched #(
    parameter int CNT_W    = 8,
    parameter int DEF_HALF = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] half_cur
`ifdef DIV_SCHED_PCNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEF_HALF_V = CNT_W'(DEF_HALF);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] half_cur_q, half_cur_d;
    logic             pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;
`ifdef DIV_SCHED_PCNT_EN
    logic [15:0]      pcnt_q, pcnt_d;
`endif

    logic [CNT_W-1:0] cfg_clamped;
    logic             accept;
    logic             term;
    logic             run_fall;

    assign cfg_clamped = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
    assign accept      = cfg_valid && !pend_valid_q;
    assign term        = (cnt_q == half_cur_q - CNT_W'(1));
    // Terminal count while high: the end of a full period.
    assign run_fall    = (state_q != S_IDLE) && term && clk_out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            busy_q       <= 1'b0;
            half_cur_q   <= DEF_HALF_V;
            pend_valid_q <= 1'b0;
            pend_half_q  <= '0;
`ifdef DIV_SCHED_PCNT_EN
            pcnt_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
            busy_q       <= busy_d;
            half_cur_q   <= half_cur_d;
            pend_valid_q <= pend_valid_d;
            pend_half_q  <= pend_half_d;
`ifdef DIV_SCHED_PCNT_EN
            pcnt_q       <= pcnt_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clk_out_d    = clk_out_q;
        tick_d       = 1'b0;
        half_cur_d   = half_cur_q;
        pend_valid_d = pend_valid_q;
        pend_half_d  = pend_half_q;

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                // A config caught on the final fall of a stop arrives here
                // still pending; with no boundary to wait for, apply it now.
                if (pend_valid_q) begin
                    half_cur_d   = pend_half_q;
                    pend_valid_d = 1'b0;
                end else if (accept) begin
                    half_cur_d = cfg_clamped;
                end
                if (en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN, S_STOPPING: begin
                if (term) begin
                    cnt_d     = '0;
                    clk_out_d = !clk_out_q;
                    tick_d    = !clk_out_q;
                    if (clk_out_q && pend_valid_q) begin
                        half_cur_d   = pend_half_q;
                        pend_valid_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // accept implies the slot is empty, so this never collides
                // with the slot being drained above.
                if (accept) begin
                    pend_valid_d = 1'b1;
                    pend_half_d  = cfg_clamped;
                end
                if (state_q == S_RUN) begin
                    if (!en) begin
                        state_d = S_STOPPING;
                    end
                end else if (en) begin
                    state_d = S_RUN;
                end else if (run_fall) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

`ifdef DIV_SCHED_PCNT_EN
    always_comb begin
        pcnt_d = pcnt_q;
        if (run_fall && (pcnt_q != 16'hFFFF)) begin
            pcnt_d = pcnt_q + 16'd1;
        end
    end

    assign period_cnt = pcnt_q;
`endif

    assign cfg_ready = !pend_valid_q;
    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign busy      = busy_q;
    assign half_cur  = half_cur_q;

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched - self-checking bench for div_sched.
// Expected first-rise latencies and fall-to-fall periods are queued when the
// stimulus is driven; a monitor pops and compares them as clk_out moves.

module tb_div_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_half;
    logic       cfg_ready;
    logic       clk_out;
    logic       tick;
    logic       busy;
    logic [7:0] half_cur;
`ifdef DIV_SCHED_PCNT_EN
    logic [15:0] period_cnt;
`endif

    div_sched #(
        .CNT_W    (8),
        .DEF_HALF (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .half_cur  (half_cur)
`ifdef DIV_SCHED_PCNT_EN
        ,
        .period_cnt(period_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks;
    int n_pass;

    int exp_first[$];
    int exp_per[$];

    int run_start;
    int last_fall;
    int rise_cyc;
    int last_high;
    int rise_cnt;
    int fall_cnt;
    int bad_tick;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic clk_prev;
        logic busy_prev;
        bit   first_pend;
        clk_prev   = 1'b0;
        busy_prev  = 1'b0;
        first_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                clk_prev   = 1'b0;
                busy_prev  = 1'b0;
                first_pend = 1'b0;
                fall_cnt   = 0;
            end else begin
                if (busy && !busy_prev) begin
                    run_start  = cyc;
                    last_fall  = cyc;
                    first_pend = 1'b1;
                end
                if (clk_out && !clk_prev) begin
                    rise_cnt++;
                    rise_cyc = cyc;
                    check_eq("tick_at_rise", int'(tick), 1);
                    if (first_pend) begin
                        first_pend = 1'b0;
                        if (exp_first.size() > 0)
                            check_eq("first_rise", cyc - run_start, exp_first.pop_front());
                    end
                end else if (tick) begin
                    bad_tick++;
                end
                if (!clk_out && clk_prev) begin
                    fall_cnt++;
                    last_high = cyc - rise_cyc;
                    if (exp_per.size() > 0)
                        check_eq("period", cyc - last_fall, exp_per.pop_front());
                    last_fall = cyc;
                end
                clk_prev  = clk_out;
                busy_prev = busy;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input logic [7:0] v, output int stalls);
        stalls    = 0;
        cfg_valid = 1'b1;
        cfg_half  = v;
        while (!cfg_ready && stalls < 100) begin
            step();
            stalls++;
        end
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_first.size() + exp_per.size()) != 0 && n < 300) begin
            step();
            n++;
        end
        check_eq(tag, exp_first.size() + exp_per.size(), 0);
        exp_first.delete();
        exp_per.delete();
    endtask

    task automatic wait_clk_out(input logic v, input string tag);
        int n;
        n = 0;
        while (clk_out !== v && n < 100) begin
            step();
            n++;
        end
        check_eq(tag, int'(clk_out), int'(v));
    endtask

    task automatic wait_busy(input logic v, input string tag);
        int n;
        n = 0;
        while (busy !== v && n < 100) begin
            step();
            n++;
        end
        check_eq(tag, int'(busy), int'(v));
    endtask

    initial begin
        int st;
        int n;
        int r0;
        reset     = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = 8'd0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_clk_out", int'(clk_out), 0);
        check_eq("rst_tick", int'(tick), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_half", int'(half_cur), 2);
        check_eq("rst_ready", int'(cfg_ready), 1);
`ifdef DIV_SCHED_PCNT_EN
        check_eq("rst_pcnt", int'(period_cnt), 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        step();

        // Default divide-by-4
        en = 1'b1;
        exp_first.push_back(2);
        repeat (3) exp_per.push_back(4);
        wait_drain("t1_drain");
        check_eq("t1_half", int'(half_cur), 2);
        check_eq("t1_high", last_high, 2);
        en = 1'b0;
        wait_busy(1'b0, "t1_stop");
        check_eq("t1_idle_low", int'(clk_out), 0);

        // Config in IDLE, then run at half 5
        send_cfg(8'd5, st);
        check_eq("t2_idle_half", int'(half_cur), 5);
        check_eq("t2_idle_ready", int'(cfg_ready), 1);
        en = 1'b1;
        exp_first.push_back(5);
        repeat (2) exp_per.push_back(10);
        wait_drain("t2_drain");
        check_eq("t2_high", last_high, 5);
        en = 1'b0;
        wait_busy(1'b0, "t2_stop");
        send_cfg(8'd2, st);
        check_eq("t2_restore", int'(half_cur), 2);

        // Reconfigure 2 -> 3 in the first cycle of a high phase
        en = 1'b1;
        exp_first.push_back(2);
        exp_per.push_back(4);
        wait_drain("t3_pre");
        wait_clk_out(1'b1, "t3_rise");
        exp_per.push_back(4);
        exp_per.push_back(6);
        exp_per.push_back(6);
        send_cfg(8'd3, st);
        check_eq("t3_ready_drop", int'(cfg_ready), 0);
        wait_clk_out(1'b0, "t3_fall");
        check_eq("t3_half_at_fall", int'(half_cur), 3);
        check_eq("t3_ready_free", int'(cfg_ready), 1);
        wait_drain("t3_drain");
        check_eq("t3_high", last_high, 3);

        // Back-to-back 7 then 0; the second stalls until the first lands
        exp_per.push_back(6);
        exp_per.push_back(14);
        repeat (3) exp_per.push_back(2);
        send_cfg(8'd7, st);
        send_cfg(8'd0, st);
        check_eq("t4_stall", st, 4);
        wait_drain("t4_drain");
        check_eq("t4_clamp", int'(half_cur), 1);

        // Same value, offered on the boundary cycle: waits one more boundary
        exp_per.push_back(2);
        exp_per.push_back(2);
        send_cfg(8'd1, st);
        check_eq("t4_same_full", int'(cfg_ready), 0);
        n = 0;
        while (!cfg_ready && n < 20) begin
            step();
            n++;
        end
        check_eq("t4_same_free", n, 2);
        check_eq("t4_same_half", int'(half_cur), 1);
        wait_drain("t4_same_drain");
        en = 1'b0;
        wait_busy(1'b0, "t4_stop");
        send_cfg(8'd4, st);
        check_eq("t4_restore", int'(half_cur), 4);

        // en dropped during the low phase: low and high both complete
        en = 1'b1;
        exp_first.push_back(4);
        exp_per.push_back(8);
        step();
        step();
        en = 1'b0;
        wait_drain("t5a_drain");
        wait_busy(1'b0, "t5a_stop");
        check_eq("t5a_low", int'(clk_out), 0);

        // en dropped one cycle after a rise
        en = 1'b1;
        exp_first.push_back(4);
        exp_per.push_back(8);
        wait_clk_out(1'b1, "t5b_rise");
        step();
        en = 1'b0;
        wait_clk_out(1'b0, "t5b_fall");
        check_eq("t5b_busy", int'(busy), 0);
        check_eq("t5b_high", cyc - rise_cyc, 4);
        r0 = rise_cnt;
        repeat (10) step();
        check_eq("t5b_no_rise", rise_cnt, r0);
        check_eq("t5b_low", int'(clk_out), 0);
        wait_drain("t5b_drain");

        // en re-asserted during STOPPING: no gap
        en = 1'b1;
        exp_first.push_back(4);
        repeat (3) exp_per.push_back(8);
        wait_clk_out(1'b1, "t5c_rise");
        step();
        en = 1'b0;
        step();
        check_eq("t5c_stopping_busy", int'(busy), 1);
        en = 1'b1;
        wait_drain("t5c_drain");
        check_eq("t5c_busy", int'(busy), 1);

        // Reset mid-period with a config pending
`ifdef DIV_SCHED_PCNT_EN
        check_eq("t6_pcnt", int'(period_cnt), fall_cnt);
`endif
        send_cfg(8'd6, st);
        check_eq("t6_pending", int'(cfg_ready), 0);
        wait_clk_out(1'b1, "t6_high");
        #2;
        reset = 1'b1;
        en    = 1'b0;
        #1;
        check_eq("t6_clk_out", int'(clk_out), 0);
        check_eq("t6_tick", int'(tick), 0);
        check_eq("t6_busy", int'(busy), 0);
        check_eq("t6_half", int'(half_cur), 2);
        check_eq("t6_ready", int'(cfg_ready), 1);
`ifdef DIV_SCHED_PCNT_EN
        check_eq("t6_pcnt_rst", int'(period_cnt), 0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        step();
        en = 1'b1;
        exp_first.push_back(2);
        repeat (2) exp_per.push_back(4);
        wait_drain("t6_post_drain");
        check_eq("t6_post_half", int'(half_cur), 2);
        en = 1'b0;
        wait_busy(1'b0, "t6_stop");
        check_eq("stray_tick", bad_tick, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
